// File: rtl/sync_link_pkg.sv
// Constants, state encoding and parity helper shared by both ends of the sync-word bit-stream link.
// The frame length depends on the SYNC_FRAME_TX_PARITY_EN macro.
package sync_link_pkg;

    localparam logic [15:0] SYNC_WORD_DEF = 16'hAFAF;
    localparam int          WINDOW_DEF    = 1000;
    localparam int          GAP_BITS_DEF  = 2;
    localparam int          CW_DEF        = 10;

`ifdef SYNC_FRAME_TX_PARITY_EN
    localparam int FRAME_LEN = 33;
`else
    localparam int FRAME_LEN = 32;
`endif

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SYNC    = 3'd1,
        PAYLOAD = 3'd2,
        PARITY  = 3'd3,
        GAP     = 3'd4
    } tx_state_e;

    function automatic logic even_parity16(input logic [15:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/sync_window_timer.sv
// Free-running window counter with a registered last-cycle tick and a "whole frame still fits" flag.
// The receive end reuses it with the same parameters, so both ends agree on the window boundaries.
module sync_window_timer #(
    parameter int WINDOW    = 1000,
    parameter int CW        = 10,
    parameter int FRAME_LEN = 32
) (
    input  logic clock,
    input  logic reset,
    output logic window_tick,
    output logic room
);

    logic [CW-1:0] win_cnt_r;
    logic          window_tick_r;

    // Window counter and tick; the tick is set one cycle early so it is high while win_cnt_r sits at WINDOW-1.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            win_cnt_r     <= {CW{1'b0}};
            window_tick_r <= 1'b0;
        end else begin
            if (win_cnt_r == CW'(WINDOW - 1)) begin
                win_cnt_r <= {CW{1'b0}};
            end else begin
                win_cnt_r <= win_cnt_r + CW'(1);
            end
            window_tick_r <= (win_cnt_r == CW'(WINDOW - 2));
        end
    end

    assign window_tick = window_tick_r;
    assign room        = (win_cnt_r <= CW'(WINDOW - 2 - FRAME_LEN));

endmodule

// File: rtl/sync_frame_tx.sv
// Serial frame transmitter: SYNC_WORD, payload MSB-first, optional parity bit, then idle gap bits.
// Define SYNC_FRAME_TX_PARITY_EN to append the even-parity bit (FRAME_LEN becomes 33).
module sync_frame_tx
    import sync_link_pkg::*;
#(
    parameter logic [15:0] SYNC_WORD = SYNC_WORD_DEF,
    parameter int          WINDOW    = WINDOW_DEF,
    parameter int          GAP_BITS  = GAP_BITS_DEF,
    parameter int          CW        = CW_DEF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        data,
    output logic        busy,
    output logic [15:0] frames_sent,
    output logic        window_tick
);

    tx_state_e   state_r, state_next_s;
    logic [3:0]  cnt_r, cnt_next_s;
    logic [15:0] shift_r;
    logic [15:0] frames_sent_r;
    logic        data_r, busy_r;
    logic        data_next_s, last_bit_next_s;
    logic        accept_s, room_s, tick_s;
`ifdef SYNC_FRAME_TX_PARITY_EN
    logic        parity_r;
`endif

    sync_window_timer #(
        .WINDOW    (WINDOW),
        .CW        (CW),
        .FRAME_LEN (FRAME_LEN)
    ) u_timer (
        .clock       (clock),
        .reset       (reset),
        .window_tick (tick_s),
        .room        (room_s)
    );

    assign in_ready = !reset && (state_r == IDLE) && room_s;
    assign accept_s = in_valid && in_ready;

    // State register and per-state bit counter.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
            cnt_r   <= 4'd0;
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
        end
    end

    // Next-state logic: each phase lasts a fixed number of bit cycles.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r + 4'd1;
        case (state_r)
            IDLE: begin
                cnt_next_s = 4'd0;
                if (accept_s) begin
                    state_next_s = SYNC;
                end else begin
                    state_next_s = IDLE;
                end
            end
            SYNC: begin
                if (cnt_r == 4'd15) begin
                    state_next_s = PAYLOAD;
                    cnt_next_s   = 4'd0;
                end else begin
                    state_next_s = SYNC;
                end
            end
            PAYLOAD: begin
                if (cnt_r == 4'd15) begin
`ifdef SYNC_FRAME_TX_PARITY_EN
                    state_next_s = PARITY;
`else
                    state_next_s = GAP;
`endif
                    cnt_next_s   = 4'd0;
                end else begin
                    state_next_s = PAYLOAD;
                end
            end
            PARITY: begin
                state_next_s = GAP;
                cnt_next_s   = 4'd0;
            end
            GAP: begin
                if (cnt_r == 4'(GAP_BITS - 1)) begin
                    state_next_s = IDLE;
                    cnt_next_s   = 4'd0;
                end else begin
                    state_next_s = GAP;
                end
            end
            default: begin
                state_next_s = IDLE;
                cnt_next_s   = 4'd0;
            end
        endcase
    end

    // Output decode from the upcoming state, so data can be registered without adding latency.
    always_comb begin
        data_next_s     = 1'b0;
        last_bit_next_s = 1'b0;
        case (state_next_s)
            SYNC: begin
                data_next_s = SYNC_WORD[4'd15 - cnt_next_s];
            end
            PAYLOAD: begin
                data_next_s = shift_r[15];
`ifdef SYNC_FRAME_TX_PARITY_EN
                last_bit_next_s = 1'b0;
`else
                if (cnt_next_s == 4'd15) begin
                    last_bit_next_s = 1'b1;
                end else begin
                    last_bit_next_s = 1'b0;
                end
`endif
            end
            PARITY: begin
`ifdef SYNC_FRAME_TX_PARITY_EN
                data_next_s     = parity_r;
                last_bit_next_s = 1'b1;
`else
                data_next_s     = 1'b0;
                last_bit_next_s = 1'b0;
`endif
            end
            default: begin
                data_next_s     = 1'b0;
                last_bit_next_s = 1'b0;
            end
        endcase
    end

    // Payload shifter: loaded on accept, shifted once per payload bit sent.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            shift_r <= 16'h0000;
        end else if (accept_s) begin
            shift_r <= in_data;
        end else if (state_next_s == PAYLOAD) begin
            shift_r <= {shift_r[14:0], 1'b0};
        end else begin
            shift_r <= shift_r;
        end
    end

`ifdef SYNC_FRAME_TX_PARITY_EN
    // Parity is captured at accept time so it never depends on the shifted copy.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            parity_r <= 1'b0;
        end else if (accept_s) begin
            parity_r <= even_parity16(in_data);
        end else begin
            parity_r <= parity_r;
        end
    end
`endif

    // Registered outputs; the window clear takes priority over a completing frame.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            data_r        <= 1'b0;
            busy_r        <= 1'b0;
            frames_sent_r <= 16'h0000;
        end else begin
            data_r <= data_next_s;
            busy_r <= (state_next_s != IDLE);
            if (tick_s) begin
                frames_sent_r <= 16'h0000;
            end else if (last_bit_next_s && (frames_sent_r != 16'hFFFF)) begin
                frames_sent_r <= frames_sent_r + 16'd1;
            end else begin
                frames_sent_r <= frames_sent_r;
            end
        end
    end

    assign data        = data_r;
    assign busy        = busy_r;
    assign frames_sent = frames_sent_r;
    assign window_tick = tick_s;

endmodule

// File: tb/tb_sync_frame_tx.sv
// Randomized scoreboard bench for sync_frame_tx: accepted words become expected per-cycle bit records
// that a negedge monitor pops and compares, alongside window, ready and frame-count expectations.
`timescale 1ns/1ps
module tb_sync_frame_tx;

    localparam int          W   = 1000;
    localparam int          GAP = 2;
    localparam logic [15:0] SW  = 16'hAFAF;
`ifdef SYNC_FRAME_TX_PARITY_EN
    localparam int FL = 33;
`else
    localparam int FL = 32;
`endif
    localparam int EXP_PEAK = (W - 2 - FL) / (FL + GAP + 1) + 1;

    typedef struct {
        int   at;
        logic b;
        logic last;
    } exp_t;

    logic        clock    = 1'b0;
    logic        reset    = 1'b1;
    logic [15:0] in_data  = 16'h0000;
    logic        in_valid = 1'b0;
    logic        in_ready, data, busy, window_tick;
    logic [15:0] frames_sent;

    exp_t        exp_q[$];
    int          cyc = 0;
    int          free_at = 0;
    bit          exp_ready_c = 1'b0;
    int          checks = 0;
    int          errors = 0;
    bit          peak_on = 1'b0;
    int          cont_win = 0;
    int          exp_fs = 0;
    logic [15:0] prev_fs = 16'h0000;
    exp_t        mon_e;
    logic        e_b, e_busy, e_last;

    sync_frame_tx dut (
        .clock       (clock),
        .reset       (reset),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .data        (data),
        .busy        (busy),
        .frames_sent (frames_sent),
        .window_tick (window_tick)
    );

    always #5 clock = ~clock;

    // Bench time base: cycle index since the last reset release; the window position is cyc % W.
    always @(posedge clock or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic bit model_ready(input int c);
        return (c >= free_at) && ((c % W) <= (W - 2 - FL));
    endfunction

    // Expected frame: SYNC then payload MSB-first, parity (if built in), then GAP zero bits.
    task automatic push_frame(input logic [15:0] w, input int c);
        logic [32:0] bits;
        exp_t        e;
        bits = {SW, w, ^w};
        for (int k = 0; k < FL + GAP; k++) begin
            e.at   = c + 1 + k;
            e.b    = (k < FL) ? bits[32 - k] : 1'b0;
            e.last = (k == FL - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic tick_cycle(output bit acc);
        exp_ready_c = model_ready(cyc);
        acc = in_valid && exp_ready_c;
        if (acc) begin
            push_frame(in_data, cyc);
            free_at = cyc + FL + GAP + 1;
        end
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        bit acc;
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) tick_cycle(acc);
    endtask

    task automatic send_word(input logic [15:0] w, input bit keep);
        bit acc;
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = w;
        do begin
            tick_cycle(acc);
            n++;
        end while (!acc && n < 2 * W);
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: word %0h not accepted within %0d cycles", w, 2 * W);
        end
        if (!keep) in_valid = 1'b0;
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_data"}, 32'(data), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_frames_sent"}, 32'(frames_sent), 0);
        check({tag, "_window_tick"}, 32'(window_tick), 0);
        check({tag, "_in_ready"}, 32'(in_ready), 0);
    endtask

    // Monitor: pops the expected record for this cycle and compares every output.
    always @(negedge clock) begin
        if (reset) begin
            exp_fs  = 0;
            prev_fs = 16'h0000;
        end else begin
            e_b = 1'b0; e_busy = 1'b0; e_last = 1'b0;
            if (exp_q.size() > 0 && exp_q[0].at == cyc) begin
                mon_e  = exp_q.pop_front();
                e_b    = mon_e.b;
                e_busy = 1'b1;
                e_last = mon_e.last;
            end
            if (cyc % W == 0)                  exp_fs = 0;
            else if (e_last && exp_fs < 65535) exp_fs = exp_fs + 1;
            check("data", 32'(data), 32'(e_b));
            check("busy", 32'(busy), 32'(e_busy));
            check("frames_sent", 32'(frames_sent), exp_fs);
            check("window_tick", 32'(window_tick), (cyc % W == W - 1) ? 1 : 0);
            check("in_ready", 32'(in_ready), 32'(exp_ready_c));
            if (window_tick === 1'b1) begin
                check("fs_change_on_tick", 32'(frames_sent), 32'(prev_fs));
                if (peak_on && (cyc / W) >= cont_win) check("window_peak", 32'(frames_sent), EXP_PEAK);
            end
            prev_fs = frames_sent;
        end
    end

    initial begin
        bit acc;
        repeat (3) @(posedge clock);
        #1;
        reset_checks("reset");
        reset = 1'b0;

        // Single word accepted at window position 5.
        while (cyc < 5) tick_cycle(acc);
        send_word(16'h1234, 1'b0);
        idle(45);

        // Three words back-to-back with valid held.
        send_word(16'h0001, 1'b1);
        send_word(16'h0003, 1'b1);
        send_word(16'($urandom), 1'b0);
        idle(45);

        // Request arriving too close to the window end waits for the next window.
        while (cyc % W != W - 1 - FL) tick_cycle(acc);
        send_word(16'($urandom), 1'b0);
        idle(45);

        // Asynchronous reset in the middle of the payload.
        send_word(16'hC3A5, 1'b0);
        idle(20);
        reset = 1'b1;
        exp_q.delete();
        free_at = 0;
        #1;
        reset_checks("midreset");
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        send_word(16'($urandom), 1'b0);
        idle(45);

        // Random words with random idle spacing, including the sync pattern as payload.
        send_word(16'hAFAF, 1'b0);
        repeat (6) begin
            send_word(16'($urandom), 1'b0);
            idle(int'($urandom_range(0, 40)));
        end

        // Continuous traffic over three full windows.
        while (cyc % W != W - 20) tick_cycle(acc);
        cont_win = cyc / W + 1;
        peak_on  = 1'b1;
        while (cyc / W < cont_win + 3) send_word(16'($urandom), 1'b1);
        peak_on  = 1'b0;
        in_valid = 1'b0;
        idle(60);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        checks++;
        errors++;
        $display("FAIL watchdog: run did not complete by time %0t", $time);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
